// File: rtl/flash_arbiter.sv
// Two-port round-robin arbiter in front of a flash_io word-access engine.
// Turns single-cycle-ack requests into the level-held fl_is_* / fl_ack handshake.
module flash_arbiter #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [1:0]  m0_cmd,
  input  logic [21:0] m0_addr,
  input  logic [15:0] m0_wdata,
  output logic [15:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [1:0]  m1_cmd,
  input  logic [21:0] m1_addr,
  input  logic [15:0] m1_wdata,
  output logic [15:0] m1_rdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [21:0] fl_addr,
  output logic [15:0] fl_data_wt,
  input  logic [15:0] fl_data_rd,
  output logic        fl_is_read,
  output logic        fl_is_write,
  output logic        fl_is_erase,
  input  logic        fl_ack,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ISSUE   = 2'b01,
    WAIT    = 2'b10,
    RELEASE = 2'b11
  } state_t;

  localparam logic [1:0]       CMD_READ    = 2'b00;
  localparam logic [1:0]       CMD_WRITE   = 2'b01;
  localparam logic [1:0]       CMD_ERASE   = 2'b10;
  localparam logic [1:0]       CMD_ILLEGAL = 2'b11;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t             state_r, state_s;
  logic               last_grant_r, last_grant_s;
  logic               gnt_r, gnt_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [21:0]        fl_addr_s;
  logic [15:0]        fl_data_wt_s;
  logic               fl_rd_s, fl_wr_s, fl_er_s;
  logic               m0_ack_s, m0_err_s, m1_ack_s, m1_err_s;
  logic [15:0]        m0_rdata_s, m1_rdata_s;
  logic               busy_s;

  logic               pick_s;
  logic               can_grant_s;
  logic [1:0]         sel_cmd_s;
  logic [21:0]        sel_addr_s;
  logic [15:0]        sel_wdata_s;

  // Contention goes to the port that did not win last; a lone requester wins outright.
  assign pick_s      = (m0_req && m1_req) ? ~last_grant_r : m1_req;
  assign sel_cmd_s   = pick_s ? m1_cmd   : m0_cmd;
  assign sel_addr_s  = pick_s ? m1_addr  : m0_addr;
  assign sel_wdata_s = pick_s ? m1_wdata : m0_wdata;
  // While an ack is on the wire the requester has not yet dropped req, so hold off.
  assign can_grant_s = ~fl_ack & (m0_req | m1_req) & ~m0_ack & ~m1_ack;

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_s      = state_r;
    last_grant_s = last_grant_r;
    gnt_s        = gnt_r;
    cnt_s        = cnt_r;
    fl_addr_s    = fl_addr;
    fl_data_wt_s = fl_data_wt;
    fl_rd_s      = fl_is_read;
    fl_wr_s      = fl_is_write;
    fl_er_s      = fl_is_erase;
    m0_ack_s     = 1'b0;
    m0_err_s     = 1'b0;
    m1_ack_s     = 1'b0;
    m1_err_s     = 1'b0;
    m0_rdata_s   = m0_rdata;
    m1_rdata_s   = m1_rdata;
    busy_s       = 1'b0;

    case (state_r)
      IDLE: begin
        if (can_grant_s) begin
          gnt_s        = pick_s;
          last_grant_s = pick_s;
          fl_addr_s    = sel_addr_s;
          fl_data_wt_s = sel_wdata_s;
          if (sel_cmd_s == CMD_ILLEGAL) begin
            if (pick_s) begin
              m1_ack_s = 1'b1;
              m1_err_s = 1'b1;
            end else begin
              m0_ack_s = 1'b1;
              m0_err_s = 1'b1;
            end
            state_s = IDLE;
          end else begin
            // Command goes out on the grant edge so it is visible the very next cycle.
            fl_rd_s = (sel_cmd_s == CMD_READ);
            fl_wr_s = (sel_cmd_s == CMD_WRITE);
            fl_er_s = (sel_cmd_s == CMD_ERASE);
            state_s = ISSUE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        cnt_s   = '0;
        state_s = WAIT;
      end
      WAIT: begin
        if (fl_ack) begin
          if (gnt_r) begin
            m1_ack_s = 1'b1;
            if (fl_is_read) begin
              m1_rdata_s = fl_data_rd;
            end else begin
              m1_rdata_s = m1_rdata;
            end
          end else begin
            m0_ack_s = 1'b1;
            if (fl_is_read) begin
              m0_rdata_s = fl_data_rd;
            end else begin
              m0_rdata_s = m0_rdata;
            end
          end
          fl_rd_s = 1'b0;
          fl_wr_s = 1'b0;
          fl_er_s = 1'b0;
          state_s = RELEASE;
        end else if (cnt_r == CNT_LAST) begin
          if (gnt_r) begin
            m1_ack_s = 1'b1;
            m1_err_s = 1'b1;
          end else begin
            m0_ack_s = 1'b1;
            m0_err_s = 1'b1;
          end
          fl_rd_s = 1'b0;
          fl_wr_s = 1'b0;
          fl_er_s = 1'b0;
          state_s = RELEASE;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      RELEASE: begin
        if (!fl_ack) begin
          state_s = IDLE;
        end else begin
          state_s = RELEASE;
        end
      end
      default: begin
        fl_rd_s = 1'b0;
        fl_wr_s = 1'b0;
        fl_er_s = 1'b0;
        state_s = IDLE;
      end
    endcase

    busy_s = (state_s != IDLE);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      gnt_r        <= 1'b0;
      cnt_r        <= '0;
      fl_addr      <= 22'd0;
      fl_data_wt   <= 16'd0;
      fl_is_read   <= 1'b0;
      fl_is_write  <= 1'b0;
      fl_is_erase  <= 1'b0;
      m0_ack       <= 1'b0;
      m0_err       <= 1'b0;
      m0_rdata     <= 16'd0;
      m1_ack       <= 1'b0;
      m1_err       <= 1'b0;
      m1_rdata     <= 16'd0;
      busy         <= 1'b0;
    end else begin
      state_r      <= state_s;
      last_grant_r <= last_grant_s;
      gnt_r        <= gnt_s;
      cnt_r        <= cnt_s;
      fl_addr      <= fl_addr_s;
      fl_data_wt   <= fl_data_wt_s;
      fl_is_read   <= fl_rd_s;
      fl_is_write  <= fl_wr_s;
      fl_is_erase  <= fl_er_s;
      m0_ack       <= m0_ack_s;
      m0_err       <= m0_err_s;
      m0_rdata     <= m0_rdata_s;
      m1_ack       <= m1_ack_s;
      m1_err       <= m1_err_s;
      m1_rdata     <= m1_rdata_s;
      busy         <= busy_s;
    end
  end

endmodule

// File: tb/tb_flash_arbiter.sv
// Directed bench for flash_arbiter with a small behavioural flash_io responder.
module tb_flash_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m1_req;
  logic [1:0]  m0_cmd, m1_cmd;
  logic [21:0] m0_addr, m1_addr;
  logic [15:0] m0_wdata, m1_wdata;
  logic [15:0] m0_rdata, m1_rdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [21:0] fl_addr;
  logic [15:0] fl_data_wt, fl_data_rd;
  logic        fl_is_read, fl_is_write, fl_is_erase;
  logic        fl_ack;
  logic        busy;

  logic        model_en = 1'b1;
  logic        model_ack = 1'b0;
  logic        man_ack = 1'b0;
  int          model_delay = 2;
  int          mcnt = 0;
  logic [15:0] rd_key = 16'h0000;
  logic        multi_hi = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  assign fl_ack     = model_ack | man_ack;
  assign fl_data_rd = fl_addr[15:0] ^ rd_key;

  flash_arbiter #(.TIMEOUT_CYCLES(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .fl_addr(fl_addr), .fl_data_wt(fl_data_wt), .fl_data_rd(fl_data_rd),
    .fl_is_read(fl_is_read), .fl_is_write(fl_is_write), .fl_is_erase(fl_is_erase),
    .fl_ack(fl_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  // flash_io stand-in: ack model_delay+1 cycles into a command, hold until commands drop.
  always @(posedge clk) begin
    if (!model_en || !(fl_is_read || fl_is_write || fl_is_erase)) begin
      model_ack <= 1'b0;
      mcnt      <= 0;
    end else if (mcnt >= model_delay) begin
      model_ack <= 1'b1;
    end else begin
      mcnt <= mcnt + 1;
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0 && $countones({fl_is_read, fl_is_write, fl_is_erase}) > 1)
      multi_hi <= 1'b1;
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ack(input int p, input int budget, output bit seen, output int cycles);
    seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if ((p == 0 && m0_ack === 1'b1) || (p == 1 && m1_ack === 1'b1)) seen = 1'b1;
    end
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    ok = 1'b0;
    while (!ok && n < 100) begin
      @(negedge clk);
      n++;
      if (busy === 1'b0 && fl_ack === 1'b0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if ({fl_is_read, fl_is_write, fl_is_erase} !== 3'b000) begin n_fail++; $display("FAIL reset_fl_is: got %b expected 000", {fl_is_read, fl_is_write, fl_is_erase}); end
    n_checks++; if ({m0_ack, m0_err, m1_ack, m1_err} !== 4'b0000) begin n_fail++; $display("FAIL reset_acks: got %b expected 0000", {m0_ack, m0_err, m1_ack, m1_err}); end
    n_checks++; if (fl_addr !== 22'd0 || fl_data_wt !== 16'd0) begin n_fail++; $display("FAIL reset_fl_bus: got %h/%h expected 0/0", fl_addr, fl_data_wt); end
    n_checks++; if (m0_rdata !== 16'd0 || m1_rdata !== 16'd0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h expected 0/0", m0_rdata, m1_rdata); end
  endtask

  task automatic test_single_read();
    int hi = 0;
    int n = 0;
    bit ok;
    model_delay = 12;
    rd_key = 16'hBEEF ^ 16'h0123;
    m0_cmd = 2'b00; m0_addr = 22'h000123; m0_req = 1'b1;
    @(negedge clk);
    n_checks++; if (fl_is_read !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL read_issue: got rd=%b busy=%b expected 1/1", fl_is_read, busy); end
    n_checks++; if (fl_addr !== 22'h000123) begin n_fail++; $display("FAIL read_addr: got %h expected 000123", fl_addr); end
    if (fl_is_read === 1'b1) hi++;
    while (m0_ack !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
      if (m0_ack !== 1'b1 && fl_is_read === 1'b1) hi++;
    end
    n_checks++; if (m0_ack !== 1'b1) begin n_fail++; $display("FAIL read_ack: got %b expected 1", m0_ack); end
    n_checks++; if (hi < 12) begin n_fail++; $display("FAIL read_held: got %0d cycles expected >= 12", hi); end
    n_checks++; if (m0_rdata !== 16'hBEEF || m0_err !== 1'b0) begin n_fail++; $display("FAIL read_data: got %h err=%b expected BEEF err=0", m0_rdata, m0_err); end
    n_checks++; if (fl_is_read !== 1'b0 || fl_ack !== 1'b1) begin n_fail++; $display("FAIL read_drop_first: got rd=%b fl_ack=%b expected 0/1", fl_is_read, fl_ack); end
    n_checks++; if (m1_ack !== 1'b0) begin n_fail++; $display("FAIL read_m1_ack: got %b expected 0", m1_ack); end
    m0_req = 1'b0;
    @(negedge clk);
    n_checks++; if (m0_ack !== 1'b0) begin n_fail++; $display("FAIL read_ack_width: got %b expected 0", m0_ack); end
    wait_idle(ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL read_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_contention();
    int n;
    int e;
    do_reset();
    model_delay = 3;
    rd_key = 16'h0000;
    m0_cmd = 2'b00; m0_addr = 22'h000AAA;
    m1_cmd = 2'b00; m1_addr = 22'h000555;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e = k % 2;
      n = 0;
      while (!(m0_ack === 1'b1 || m1_ack === 1'b1) && n < 60) begin
        @(negedge clk);
        n++;
      end
      n_checks++; if ({m1_ack, m0_ack} !== ((e == 0) ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL cont_grant%0d: got m1/m0 ack %b%b expected port %0d", k, m1_ack, m0_ack, e); end
      if (e == 0) begin
        n_checks++; if (m0_rdata !== 16'h0AAA || m0_err !== 1'b0) begin n_fail++; $display("FAIL cont_data%0d: got %h err=%b expected 0AAA", k, m0_rdata, m0_err); end
        m0_req = 1'b0;
      end else begin
        n_checks++; if (m1_rdata !== 16'h0555 || m1_err !== 1'b0) begin n_fail++; $display("FAIL cont_data%0d: got %h err=%b expected 0555", k, m1_rdata, m1_err); end
        m1_req = 1'b0;
      end
      @(negedge clk);
      if (k < 2) begin
        if (e == 0) m0_req = 1'b1; else m1_req = 1'b1;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    n_checks++; if (multi_hi !== 1'b0) begin n_fail++; $display("FAIL cont_onehot: got %b expected 0", multi_hi); end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_write_erase();
    logic [15:0] prev;
    bit seen, ok;
    int cyc;
    model_delay = 2;
    prev = m1_rdata;
    m1_cmd = 2'b01; m1_addr = 22'h000400; m1_wdata = 16'h1234; m1_req = 1'b1;
    @(negedge clk);
    n_checks++; if (fl_is_write !== 1'b1 || fl_data_wt !== 16'h1234 || fl_addr !== 22'h000400) begin n_fail++; $display("FAIL wr_issue: got wr=%b data=%h addr=%h expected 1/1234/000400", fl_is_write, fl_data_wt, fl_addr); end
    wait_ack(1, 60, seen, cyc);
    n_checks++; if (seen !== 1'b1 || m1_err !== 1'b0 || m1_rdata !== prev) begin n_fail++; $display("FAIL wr_ack: got seen=%b err=%b rdata=%h expected 1/0/%h", seen, m1_err, m1_rdata, prev); end
    m1_req = 1'b0;
    wait_idle(ok);
    m1_cmd = 2'b10; m1_wdata = 16'hFFFF; m1_req = 1'b1;
    @(negedge clk);
    n_checks++; if (fl_is_erase !== 1'b1 || fl_is_write !== 1'b0 || fl_addr !== 22'h000400) begin n_fail++; $display("FAIL er_issue: got er=%b wr=%b addr=%h expected 1/0/000400", fl_is_erase, fl_is_write, fl_addr); end
    wait_ack(1, 60, seen, cyc);
    n_checks++; if (seen !== 1'b1 || m1_err !== 1'b0 || m1_rdata !== prev) begin n_fail++; $display("FAIL er_ack: got seen=%b err=%b rdata=%h expected 1/0/%h", seen, m1_err, m1_rdata, prev); end
    m1_req = 1'b0;
    wait_idle(ok);
  endtask

  task automatic test_timeout();
    bit seen, ok;
    int cyc;
    model_en = 1'b0;
    m0_cmd = 2'b00; m0_addr = 22'h000777; m0_req = 1'b1;
    @(negedge clk);
    n_checks++; if (fl_is_read !== 1'b1) begin n_fail++; $display("FAIL to_issue: got %b expected 1", fl_is_read); end
    wait_ack(0, 100, seen, cyc);
    n_checks++; if (seen !== 1'b1 || cyc !== 17) begin n_fail++; $display("FAIL to_latency: got seen=%b cycles=%0d expected 1/17", seen, cyc); end
    n_checks++; if (m0_err !== 1'b1 || fl_is_read !== 1'b0) begin n_fail++; $display("FAIL to_err: got err=%b rd=%b expected 1/0", m0_err, fl_is_read); end
    m0_req = 1'b0;
    wait_idle(ok);
    man_ack = 1'b1;
    m1_cmd = 2'b00; m1_addr = 22'h000055; m1_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (fl_is_read !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL to_block%0d: got rd=%b busy=%b expected 0/0", i, fl_is_read, busy); end
    end
    model_en = 1'b1;
    man_ack = 1'b0;
    @(negedge clk);
    n_checks++; if (fl_is_read !== 1'b1 || fl_addr !== 22'h000055) begin n_fail++; $display("FAIL to_regrant: got rd=%b addr=%h expected 1/000055", fl_is_read, fl_addr); end
    wait_ack(1, 60, seen, cyc);
    n_checks++; if (seen !== 1'b1 || m1_rdata !== 16'h0055 || m1_err !== 1'b0) begin n_fail++; $display("FAIL to_after: got seen=%b rdata=%h err=%b expected 1/0055/0", seen, m1_rdata, m1_err); end
    m1_req = 1'b0;
    wait_idle(ok);
  endtask

  task automatic test_illegal();
    m1_cmd = 2'b11; m1_addr = 22'h00003F; m1_req = 1'b1;
    @(negedge clk);
    n_checks++; if (m1_ack !== 1'b1 || m1_err !== 1'b1) begin n_fail++; $display("FAIL ill_ack: got ack=%b err=%b expected 1/1", m1_ack, m1_err); end
    n_checks++; if ({fl_is_read, fl_is_write, fl_is_erase, busy} !== 4'b0000) begin n_fail++; $display("FAIL ill_quiet: got %b expected 0000", {fl_is_read, fl_is_write, fl_is_erase, busy}); end
    m1_req = 1'b0;
    @(negedge clk);
    n_checks++; if (m1_ack !== 1'b0 || {fl_is_read, fl_is_write, fl_is_erase} !== 3'b000) begin n_fail++; $display("FAIL ill_after: got ack=%b fl=%b expected 0/000", m1_ack, {fl_is_read, fl_is_write, fl_is_erase}); end
  endtask

  task automatic test_reset_wait();
    bit seen, ok;
    int cyc;
    model_en = 1'b0;
    m1_cmd = 2'b10; m1_addr = 22'h000200; m1_req = 1'b1;
    @(negedge clk);
    n_checks++; if (fl_is_erase !== 1'b1) begin n_fail++; $display("FAIL rw_issue: got %b expected 1", fl_is_erase); end
    repeat (3) @(negedge clk);
    rst = 1'b1; man_ack = 1'b1; m1_req = 1'b0;
    m0_cmd = 2'b00; m0_addr = 22'h000321; m0_req = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (fl_is_erase !== 1'b0 || m1_ack !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rw_drop: got er=%b ack=%b busy=%b expected 0/0/0", fl_is_erase, m1_ack, busy); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (fl_is_read !== 1'b0 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin n_fail++; $display("FAIL rw_hold%0d: got rd=%b a0=%b a1=%b expected 0/0/0", i, fl_is_read, m0_ack, m1_ack); end
    end
    man_ack = 1'b0; model_en = 1'b1;
    @(negedge clk);
    n_checks++; if (fl_is_read !== 1'b1 || fl_addr !== 22'h000321) begin n_fail++; $display("FAIL rw_grant: got rd=%b addr=%h expected 1/000321", fl_is_read, fl_addr); end
    wait_ack(0, 60, seen, cyc);
    n_checks++; if (seen !== 1'b1 || m0_rdata !== 16'h0321 || m0_err !== 1'b0) begin n_fail++; $display("FAIL rw_read: got seen=%b rdata=%h err=%b expected 1/0321/0", seen, m0_rdata, m0_err); end
    m0_req = 1'b0;
    wait_idle(ok);
    n_checks++; if (multi_hi !== 1'b0) begin n_fail++; $display("FAIL final_onehot: got %b expected 0", multi_hi); end
  endtask

  initial begin
    rst = 1'b1;
    m0_req = 1'b0; m0_cmd = 2'b00; m0_addr = 22'd0; m0_wdata = 16'd0;
    m1_req = 1'b0; m1_cmd = 2'b00; m1_addr = 22'd0; m1_wdata = 16'd0;
    @(negedge clk);
    test_reset();
    test_single_read();
    test_contention();
    test_write_erase();
    test_timeout();
    test_illegal();
    test_reset_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
